uart_cmd_arbiter: RTL and testbench
===================================

# uart_cmd_arbiter

Round-robin arbiter that shares one `uart` command port among `NUM_REQ` requesters. It sits between the requesters and the `uart` block. It issues exactly one command at a time and waits for the write to complete or for the read data to return. It then routes a response pulse back to the requester that owns the command. Reads that get no answer can be closed by a timeout.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `CMD_WIDTH`, 16 — command width: {rw_flag(1: write, 0: read), addr(7), data(8)}.
- `TIMEOUT_CYCLES`, 20000 — clocks to wait for `read_valid` after a read's TX completes.
- `clk` in 1 — system clock, 50 MHz.
- `rst_n` in 1 — asynchronous active-low reset.
- `req_valid` in NUM_REQ — requester i has a command pending.
- `req_data` in NUM_REQ*CMD_WIDTH — command of requester i, at [i*CMD_WIDTH +: CMD_WIDTH].
- `req_ready` out NUM_REQ — one-hot, combinational; accept strobe for requester i.
- `rsp_valid` out NUM_REQ — one-hot, one-cycle response pulse to the owner.
- `rsp_data` out 8 — read data, valid with `rsp_valid`; 0 for writes and timeouts.
- `rsp_err` out 1 — high with `rsp_valid` when a read timed out.
- `busy` out 1 — high in every state except IDLE.
- `uart_cmd_valid` out 1 — to uart `cmd_valid`; registered.
- `uart_cmd_data` out CMD_WIDTH — to uart `cmd_data`; registered.
- `uart_cmd_ready` in 1 — from uart `cmd_ready`.
- `uart_read_valid` in 1 — from uart `read_valid`.
- `uart_read_data` in 8 — from uart `read_data`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, WAIT_RD, RESP.
- **IDLE**
  - Arbitration runs only when `uart_cmd_ready`=1 and some `req_valid` is set.
  - Round-robin search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `req_ready[g]`=1 for the winner in that same cycle.
  - At the clock edge the arbiter latches the command, the owner index `g`, and `last_grant`<=g, then moves to ISSUE.
- **ISSUE**
  - `uart_cmd_valid`=1 for exactly one cycle, then WAIT_DONE.
  - The uart sets its work enable on any `cmd_valid`, so `uart_cmd_valid` must never be high outside ISSUE.
- **WAIT_DONE**
  - Waits for `uart_cmd_ready`=1; the uart drops it the cycle after ISSUE.
  - On `uart_cmd_ready`=1: write goes to RESP (data 0, err 0); read goes to WAIT_RD, or to RESP if read data was already captured.
- **WAIT_RD**
  - On `uart_read_valid`, capture `uart_read_data` and go to RESP with err 0.
- **RESP**
  - `rsp_valid[g]`=1, `rsp_data` and `rsp_err` driven, for one cycle; then IDLE.
- Read data capture:
  - `uart_read_valid` is accepted in WAIT_DONE and in WAIT_RD.
  - Only the first pulse per command is kept; later pulses are ignored.
  - A pulse seen in IDLE, ISSUE or RESP is dropped silently.
- Requester side:
  - `req_data` must stay stable while `req_valid` is high and unaccepted.
  - Dropping `req_valid` before it is accepted withdraws the request, with no side effect.
- A requester may re-request in the cycle after its RESP. Round-robin still gives the other pending requesters priority.

## Timing
- Reset values: `uart_cmd_valid`=0, `uart_cmd_data`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `req_ready`=0, `busy`=0. State is IDLE, `last_grant`=NUM_REQ-1, so requester 0 wins first.
- Accept to uart: accept in cycle N; `uart_cmd_valid` high in cycle N+1.
- Completion to response:
  - Write: `uart_cmd_ready` sampled high in WAIT_DONE in cycle M; `rsp_valid` high in cycle M+1.
  - Read: the edge that leaves WAIT_RD (or WAIT_DONE, if data was already captured) is followed by `rsp_valid` in the next cycle.
- Back-to-back: the earliest next accept is the cycle after RESP, i.e. a minimum 3-cycle gap between uart commands.
- Reset asserted mid-operation returns the block to IDLE at once and drops any pending response. The uart shares `rst_n`.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 15-bit counter clears on entry to WAIT_RD and increments every cycle there.
  - When it reaches `TIMEOUT_CYCLES-1` with no read data, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `uart_read_valid` in that same cycle wins, giving err 0.
- Not defined: no counter exists, WAIT_RD waits indefinitely, and `rsp_err` is tied 0.

## Test plan
- Single write from req 2, cmd 16'h85A5 → `uart_cmd_valid` pulse with data 16'h85A5 one cycle after `req_ready[2]`; one `rsp_valid[2]` with data 0 and err 0 one cycle after `uart_cmd_ready` returns high.
- Read from req 1, cmd 16'h1200; model returns 8'h3C 1000 cycles after TX → `rsp_valid[1]`, `rsp_data`=8'h3C, `rsp_err`=0.
- All four requesters hold `req_valid` continuously after reset → grant order 0,1,2,3,0; exactly one `uart_cmd_valid` per command; `uart_cmd_valid` never high while `uart_cmd_ready`=0.
- Read with no reply, `TIMEOUT_CYCLES`=50, macro on → `rsp_err`=1 and `rsp_data`=0 exactly 50 cycles after entering WAIT_RD. Macro off → no response, `busy` stays 1.
- Read where `uart_read_valid` arrives in WAIT_DONE, followed by a stray second pulse → `rsp_data` equals the first value; a stray pulse in IDLE produces no `rsp_valid`.
- `rst_n` pulsed low during WAIT_DONE → all outputs at reset values, and the next request from req 0 is granted normally.

Source files
------------

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: round-robin sharing of one uart command port among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to close unanswered reads with rsp_err after TIMEOUT_CYCLES.
module uart_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [7:0]                   rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         uart_cmd_valid,
  output logic [CMD_WIDTH-1:0]         uart_cmd_data,
  input  logic                         uart_cmd_ready,
  input  logic                         uart_read_valid,
  input  logic [7:0]                   uart_read_data
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RD, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] last_grant, win, idx;
  logic found, grant, captured, have_rd, is_write, to_err;
  logic [7:0] rd_data, rd_sel;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign grant     = rst_n && state == IDLE && uart_cmd_ready && found;
  assign req_ready = grant ? NUM_REQ'(1) << win : '0;
  assign busy      = state != IDLE;
  assign is_write  = uart_cmd_data[CMD_WIDTH-1];
  // A pulse arriving in the same cycle it is needed counts as captured.
  assign have_rd   = captured | uart_read_valid;
  assign rd_sel    = captured ? rd_data : uart_read_data;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = grant ? ISSUE : IDLE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: state_nxt = !uart_cmd_ready ? WAIT_DONE : (is_write || have_rd) ? RESP : WAIT_RD;
      WAIT_RD:   state_nxt = (have_rd || to_err) ? RESP : WAIT_RD;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IW'(NUM_REQ - 1);
      captured       <= 1'b0;
      rd_data        <= '0;
      uart_cmd_valid <= 1'b0;
      uart_cmd_data  <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
    end else begin
      state          <= state_nxt;
      uart_cmd_valid <= grant;
      rsp_valid      <= state_nxt == RESP ? NUM_REQ'(1) << last_grant : '0;
      rsp_data       <= (state_nxt == RESP && !is_write && !to_err) ? rd_sel : 8'h00;
      if (grant) begin
        last_grant    <= win;
        uart_cmd_data <= req_data[win*CMD_WIDTH +: CMD_WIDTH];
        captured      <= 1'b0;
      end else if ((state == WAIT_DONE || state == WAIT_RD) && uart_read_valid && !captured) begin
        captured <= 1'b1;
        rd_data  <= uart_read_data;
      end
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  logic [14:0] timer;
  assign to_err = state == WAIT_RD && !have_rd && timer == 15'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      rsp_err <= 1'b0;
    end else begin
      timer   <= state == WAIT_RD ? timer + 15'd1 : '0;
      rsp_err <= to_err;
    end
  end
`else
  assign to_err  = 1'b0;
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// tb_uart_cmd_arbiter: directed and randomized transactions checked against a
// transaction-level model (rotation order, one command per grant, response timing/data).
module tb_uart_cmd_arbiter;
  localparam int NR = 4;
  localparam int T  = 50;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid, req_ready, rsp_valid;
  logic [NR*16-1:0] req_data;
  logic [7:0] rsp_data, uart_read_data;
  logic rsp_err, busy, uart_cmd_valid, uart_cmd_ready, uart_read_valid;
  logic [15:0] uart_cmd_data;
  logic [15:0] cmds [NR];
  logic [NR-1:0] pend;
  int last_g, checks, failures, g;
  int order [5];

  always #10 clk = ~clk;

  uart_cmd_arbiter #(.NUM_REQ(NR), .CMD_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .uart_cmd_valid(uart_cmd_valid), .uart_cmd_data(uart_cmd_data),
    .uart_cmd_ready(uart_cmd_ready), .uart_read_valid(uart_read_valid),
    .uart_read_data(uart_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req_valid = pend;
    for (int i = 0; i < NR; i++) req_data[i*16 +: 16] = cmds[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pend = '0;
    drive_reqs();
    uart_cmd_ready = 1'b1;
    uart_read_valid = 1'b0;
    #1;
    chk("rst_cmd_valid", uart_cmd_valid, 0);
    chk("rst_cmd_data", uart_cmd_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_g = NR - 1;
  endtask

  // Caller is at a negedge of an idle cycle with pend/cmds driven and the uart ready.
  // mode: 0 reply dly cycles into WAIT_RD, 1 reply early in WAIT_DONE plus a stray
  // second pulse, 2 no reply, 3 reply together with uart_cmd_ready.
  task automatic transact(input bit keep, input int lat, input int mode, input int dly,
                          input logic [7:0] v1, input logic [7:0] v2, output int gw);
    logic [15:0] c;
    int wait_n, exp_v;
    bit rd, tmo;
    gw = -1;
    for (int k = 1; k <= NR; k++)
      if (gw < 0 && pend[(last_g + k) % NR]) gw = (last_g + k) % NR;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rsp", rsp_valid, 0);
    chk("req_ready", req_ready, 1 << gw);
    c = cmds[gw];
    rd = !c[15];
    tmo = rd && mode == 2;
    @(negedge clk);
    #1;
    chk("cmd_valid", uart_cmd_valid, 1);
    chk("cmd_data", uart_cmd_data, c);
    chk("valid_needs_ready", uart_cmd_ready, 1);
    chk("ready_while_busy", req_ready, 0);
    last_g = gw;
    if (keep) cmds[gw] = 16'($urandom);
    else pend[gw] = 1'b0;
    drive_reqs();
    uart_cmd_ready = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      uart_read_valid = mode == 1 && i == 0;
      uart_read_data = v1;
      #1;
      chk("wd_cmd_valid", uart_cmd_valid, 0);
      chk("wd_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    uart_cmd_ready = 1'b1;
    uart_read_valid = mode == 1 || mode == 3;
    uart_read_data = mode == 1 ? v2 : v1;
    #1;
    chk("m_rsp", rsp_valid, 0);
    wait_n = (!rd || mode == 1 || mode == 3) ? 0 : mode == 0 ? dly + 1 : (TMO_EN ? T : T + 10);
    for (int j = 0; j < wait_n; j++) begin
      @(negedge clk);
      uart_read_valid = rd && mode == 0 && j == dly;
      uart_read_data = v1;
      #1;
      chk("wr_rsp", rsp_valid, 0);
      chk("wr_busy", busy, 1);
    end
    @(negedge clk);
    uart_read_valid = 1'b0;
    #1;
    exp_v = (tmo && !TMO_EN) ? 0 : 1 << gw;
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v != 0) begin
      chk("rsp_data", rsp_data, (!rd || tmo) ? 8'h00 : v1);
      chk("rsp_err", rsp_err, tmo);
    end else begin
      chk("hang_busy", busy, 1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pend = '0;
    for (int i = 0; i < NR; i++) cmds[i] = '0;
    drive_reqs();
    uart_cmd_ready = 1'b1;
    uart_read_valid = 1'b0;
    uart_read_data = '0;
    do_reset();

    @(negedge clk);
    pend = 4'b0100; cmds[2] = 16'h85A5; drive_reqs();
    transact(1'b0, 3, 0, 0, 8'h00, 8'h00, g);

    @(negedge clk);
    pend = 4'b0010; cmds[1] = 16'h1200; drive_reqs();
    transact(1'b0, 2, 0, 1000, 8'h3C, 8'h00, g);

    @(negedge clk);
    uart_read_valid = 1'b1; uart_read_data = 8'h77;
    #1;
    chk("stray_idle_rsp", rsp_valid, 0);
    @(negedge clk);
    uart_read_valid = 1'b0;
    #1;
    chk("stray_idle_rsp2", rsp_valid, 0);
    chk("stray_idle_busy", busy, 0);

    @(negedge clk);
    pend = 4'b1000; cmds[3] = 16'h2A00; drive_reqs();
    transact(1'b0, 3, 1, 0, 8'hA1, 8'h5E, g);

    @(negedge clk);
    for (int i = 0; i < NR; i++) cmds[i] = 16'($urandom);
    pend = 4'b1111; drive_reqs();
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      transact(1'b1, $urandom_range(1, 4), 0, $urandom_range(0, 6), 8'($urandom), 8'($urandom), g);
      order[n] = g;
    end
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 3);
    chk("rr_order4", order[4], 0);

    @(negedge clk);
    pend = 4'b0001; cmds[0] = 16'h0500; drive_reqs();
    transact(1'b0, 2, 2, 0, 8'h00, 8'h00, g);
`ifndef UART_ARB_TIMEOUT_EN
    do_reset();
`endif

    @(negedge clk);
    pend = 4'b0010; cmds[1] = 16'h8123; drive_reqs();
    #1;
    chk("mid_grant", req_ready, 4'b0010);
    @(negedge clk);
    #1;
    chk("mid_issue", uart_cmd_valid, 1);
    pend = '0; drive_reqs(); uart_cmd_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_wait_busy", busy, 1);
    do_reset();
    @(negedge clk);
    pend = 4'b0101; cmds[0] = 16'h9011; cmds[2] = 16'h0C00; drive_reqs();
    transact(1'b0, 1, 0, 3, 8'h42, 8'h00, g);
    chk("post_rst_owner", g, 0);

    for (int n = 0; n < 40; n++) begin
      logic [NR-1:0] add;
      int md;
      @(negedge clk);
      add = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) if (add[i] && !pend[i]) cmds[i] = 16'($urandom);
      pend = pend | add;
      drive_reqs();
      md = $urandom_range(0, 3);
      if (md == 2 && (!TMO_EN || $urandom_range(0, 3) != 0)) md = 0;
      transact(1'($urandom_range(0, 1)), $urandom_range(1, 5), md, $urandom_range(0, 15),
               8'($urandom), 8'($urandom), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
